// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings, FSM states and shadow-stage record for hazard_ctrl
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int HZ_REG_W = 5;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2
  } hz_state_t;

  typedef struct packed {
    logic                valid;
    logic [HZ_REG_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } shadow_t;

  // The EX producer is younger than the MEM producer, so it takes precedence.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    if (hit_ex)
      return FWD_MEM;
    else if (hit_mem)
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - one source-register vs one shadow-stage comparator
// x0 never matches, and a source the instruction does not read never matches.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             i_id_valid,
  input  logic             i_uses,
  input  logic [REG_W-1:0] i_rs,
  input  logic             i_stage_valid,
  input  logic             i_stage_regwrite,
  input  logic [REG_W-1:0] i_stage_rd,
  output logic             o_hit
);

  logic w_live;
  logic w_same;

  assign w_live = i_id_valid & i_uses & i_stage_valid & i_stage_regwrite;
  assign w_same = (i_stage_rd == i_rs) && (i_stage_rd != '0);
  assign o_hit  = w_live & w_same;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard controller: forwarding selects, load-use stall, branch flush
// HAZARD_FWD_EN defined: forwarding active, only load-use stalls; undefined: forwards 00, any EX/MEM match stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // WB needs no shadow entry: the register file writes through to the reader.
  shadow_t r_ex;
  shadow_t r_mem;
  shadow_t w_id_stage;

  hz_state_t        r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_hit1_ex, w_hit1_mem, w_hit2_ex, w_hit2_mem;
  logic w_stall_req;
  logic w_flush;
  logic w_stall;
  logic w_bubble;
  logic [1:0] w_unused_memread;

  assign w_id_stage = {id_valid, id_rd, id_regwrite, id_memread};

  hazard_match #(.REG_W(REG_W)) u_m1_ex (
    .i_id_valid      (id_valid),
    .i_uses          (id_uses_rs1),
    .i_rs            (id_rs1),
    .i_stage_valid   (r_ex.valid),
    .i_stage_regwrite(r_ex.regwrite),
    .i_stage_rd      (r_ex.rd),
    .o_hit           (w_hit1_ex)
  );

  hazard_match #(.REG_W(REG_W)) u_m1_mem (
    .i_id_valid      (id_valid),
    .i_uses          (id_uses_rs1),
    .i_rs            (id_rs1),
    .i_stage_valid   (r_mem.valid),
    .i_stage_regwrite(r_mem.regwrite),
    .i_stage_rd      (r_mem.rd),
    .o_hit           (w_hit1_mem)
  );

  hazard_match #(.REG_W(REG_W)) u_m2_ex (
    .i_id_valid      (id_valid),
    .i_uses          (id_uses_rs2),
    .i_rs            (id_rs2),
    .i_stage_valid   (r_ex.valid),
    .i_stage_regwrite(r_ex.regwrite),
    .i_stage_rd      (r_ex.rd),
    .o_hit           (w_hit2_ex)
  );

  hazard_match #(.REG_W(REG_W)) u_m2_mem (
    .i_id_valid      (id_valid),
    .i_uses          (id_uses_rs2),
    .i_rs            (id_rs2),
    .i_stage_valid   (r_mem.valid),
    .i_stage_regwrite(r_mem.regwrite),
    .i_stage_rd      (r_mem.rd),
    .o_hit           (w_hit2_mem)
  );

`ifdef HAZARD_FWD_EN
  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;

  assign w_stall_req      = (w_hit1_ex | w_hit2_ex) & r_ex.memread;
  assign w_unused_memread = {r_mem.memread, 1'b0};
  assign forwardA         = r_fwd_a;
  assign forwardB         = r_fwd_b;
`else
  assign w_stall_req      = w_hit1_ex | w_hit2_ex | w_hit1_mem | w_hit2_mem;
  assign w_unused_memread = {r_mem.memread, r_ex.memread};
  assign forwardA         = FWD_RF;
  assign forwardB         = FWD_RF;
`endif

  // A taken branch makes the ID instruction wrong-path, so its stall is dropped.
  assign w_flush  = ex_branch_taken & ~reset;
  assign w_stall  = w_stall_req & ~ex_branch_taken & ~reset;
  assign w_bubble = w_stall | w_flush;

  assign pc_write    = ~w_stall;
  assign ifid_write  = ~w_stall;
  assign ifid_flush  = w_flush;
  assign idex_bubble = w_bubble;

  assign state       = r_state;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_state     <= HZ_RUN;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
`ifdef HAZARD_FWD_EN
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
`endif
    end else begin
      r_ex  <= w_bubble ? '0 : w_id_stage;
      r_mem <= r_ex;

      if (w_flush)
        r_state <= HZ_FLUSH;
      else if (w_stall)
        r_state <= HZ_STALL;
      else
        r_state <= HZ_RUN;

      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_ONE;

`ifdef HAZARD_FWD_EN
      // A bubble enters EX on stall/flush, so selects computed now are meaningless.
      r_fwd_a <= w_bubble ? FWD_RF : fwd_sel(w_hit1_ex, w_hit1_mem);
      r_fwd_b <= w_bubble ? FWD_RF : fwd_sel(w_hit2_ex, w_hit2_mem);
`endif
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed per-cycle vectors
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2;
  logic        id_regwrite, id_memread;
  logic        ex_branch_taken;
  logic [1:0]  forwardA, forwardB;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  state;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .ex_branch_taken(ex_branch_taken),
    .forwardA       (forwardA),
    .forwardB       (forwardB),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .state          (state),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       pcw;
    logic       ifw;
    logic       fl;
    logic       bub;
    logic [1:0] st;
    int         sc;
    int         fc;
    int         idx;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t cur;
  int   n_vec;
  int   n_miss;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t V(input int rst, v, rs1, u1, rs2, u2, rd, rw, mr, br,
                             input int fa, fb, pcw, ifw, fl, bub, st, sc, fc);
    vec_t t;
    t.rst = 1'(rst); t.v = 1'(v); t.rs1 = 5'(rs1); t.u1 = 1'(u1);
    t.rs2 = 5'(rs2); t.u2 = 1'(u2); t.rd = 5'(rd); t.rw = 1'(rw);
    t.mr = 1'(mr); t.br = 1'(br);
    t.fa = 2'(fa); t.fb = 2'(fb); t.pcw = 1'(pcw); t.ifw = 1'(ifw);
    t.fl = 1'(fl); t.bub = 1'(bub); t.st = 2'(st); t.sc = sc; t.fc = fc;
    t.idx = 0;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Monitor: every cycle that has a pending expectation, compare all outputs.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      n_vec++;
      chk("forwardA",    cur.idx, 32'(forwardA),    32'(cur.fa));
      chk("forwardB",    cur.idx, 32'(forwardB),    32'(cur.fb));
      chk("pc_write",    cur.idx, 32'(pc_write),    32'(cur.pcw));
      chk("ifid_write",  cur.idx, 32'(ifid_write),  32'(cur.ifw));
      chk("ifid_flush",  cur.idx, 32'(ifid_flush),  32'(cur.fl));
      chk("idex_bubble", cur.idx, 32'(idex_bubble), 32'(cur.bub));
      chk("state",       cur.idx, 32'(state),       32'(cur.st));
      chk("stall_count", cur.idx, stall_count,      32'(cur.sc));
      chk("flush_count", cur.idx, flush_count,      32'(cur.fc));
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    //           rst v rs1 u1 rs2 u2 rd rw mr br   fa fb pcw ifw fl bub st sc fc
`ifdef HAZARD_FWD_EN
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,0,0,0)); // reset state
    vecs.push_back(V(0,1, 1,1, 2,1, 5,1,0,0,  0,0,1,1,0,0,0,0,0)); // add x5,x1,x2
    vecs.push_back(V(0,1, 5,1, 1,1, 6,1,0,0,  0,0,1,1,0,0,0,0,0)); // add x6,x5,x1
    vecs.push_back(V(0,1, 5,1, 3,1, 7,1,0,0,  2,0,1,1,0,0,0,0,0)); // sub x7,x5,x3
    vecs.push_back(V(0,1, 1,1, 7,0, 5,1,1,0,  1,0,1,1,0,0,0,0,0)); // ld x5
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,0,0,0,1,0,0,0)); // add x6,x5,x5 stall
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,1,1,0));
    vecs.push_back(V(0,1, 1,1, 2,1, 9,1,0,0,  1,1,1,1,0,0,0,1,0)); // add x9
    vecs.push_back(V(0,1, 2,1, 3,1, 9,1,0,0,  0,0,1,1,0,0,0,1,0)); // add x9 again
    vecs.push_back(V(0,1, 9,1, 9,1,10,1,0,0,  0,0,1,1,0,0,0,1,0)); // youngest wins
    vecs.push_back(V(0,1, 2,1, 0,0, 8,1,1,0,  2,2,1,1,0,0,0,1,0)); // ld x8
    vecs.push_back(V(0,1, 8,1, 1,1, 9,1,0,1,  0,0,1,1,1,1,0,1,0)); // branch beats stall
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,2,1,1));
    vecs.push_back(V(0,1, 1,1, 0,0, 0,1,0,0,  0,0,1,1,0,0,0,1,1)); // addi x0
    vecs.push_back(V(0,1, 0,1, 0,1, 6,1,0,0,  0,0,1,1,0,0,0,1,1)); // add x6,x0,x0
    vecs.push_back(V(0,1, 0,1, 0,1, 7,1,0,0,  0,0,1,1,0,0,0,1,1));
    vecs.push_back(V(0,1, 1,1, 0,0, 5,1,1,0,  0,0,1,1,0,0,0,1,1)); // ld x5
    vecs.push_back(V(1,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,0,1,1)); // reset in stall
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,0,0,0));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,0,0,0));
    vecs.push_back(V(0,1, 1,1, 2,1,10,1,0,0,  0,0,1,1,0,0,0,0,0)); // add x10
    vecs.push_back(V(0,1, 3,1,10,1,11,1,0,0,  0,0,1,1,0,0,0,0,0)); // or x11,x3,x10
    vecs.push_back(V(0,0,11,1,10,1,12,1,0,0,  0,2,1,1,0,0,0,0,0)); // id_valid low
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,0,0,0));
    vecs.push_back(V(0,1, 1,1, 0,0,13,1,1,0,  0,0,1,1,0,0,0,0,0)); // ld x13
    vecs.push_back(V(0,1, 2,1,13,1,14,1,0,0,  0,0,0,0,0,1,0,0,0)); // rs2 load-use
    vecs.push_back(V(0,1, 2,1,13,1,14,1,0,0,  0,0,1,1,0,0,1,1,0));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,1,1,1,0,0,0,1,0));
`else
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,0,0,0)); // reset state
    vecs.push_back(V(0,1, 1,1, 2,1, 5,1,0,0,  0,0,1,1,0,0,0,0,0)); // add x5,x1,x2
    vecs.push_back(V(0,1, 5,1, 1,1, 6,1,0,0,  0,0,0,0,0,1,0,0,0)); // add x6: EX match
    vecs.push_back(V(0,1, 5,1, 1,1, 6,1,0,0,  0,0,0,0,0,1,1,1,0)); // MEM match
    vecs.push_back(V(0,1, 5,1, 1,1, 6,1,0,0,  0,0,1,1,0,0,1,2,0));
    vecs.push_back(V(0,1, 5,1, 3,1, 7,1,0,0,  0,0,1,1,0,0,0,2,0)); // sub x7,x5,x3
    vecs.push_back(V(0,1, 1,1, 7,0, 5,1,1,0,  0,0,1,1,0,0,0,2,0)); // ld x5, rs2 unused
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,0,0,0,1,0,2,0)); // load-use
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,0,0,0,1,1,3,0));
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,1,4,0));
    vecs.push_back(V(0,1, 2,1, 0,0, 8,1,1,0,  0,0,1,1,0,0,0,4,0)); // ld x8
    vecs.push_back(V(0,1, 8,1, 1,1, 9,1,0,1,  0,0,1,1,1,1,0,4,0)); // branch beats stall
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,2,4,1));
    vecs.push_back(V(0,1, 1,1, 0,0, 0,1,0,0,  0,0,1,1,0,0,0,4,1)); // addi x0
    vecs.push_back(V(0,1, 0,1, 0,1, 6,1,0,0,  0,0,1,1,0,0,0,4,1)); // add x6,x0,x0
    vecs.push_back(V(0,1, 0,1, 0,1, 7,1,0,0,  0,0,1,1,0,0,0,4,1)); // x0 in MEM
    vecs.push_back(V(0,1, 1,1, 0,0, 5,1,1,0,  0,0,1,1,0,0,0,4,1)); // ld x5
    vecs.push_back(V(1,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,0,4,1)); // reset in stall
    vecs.push_back(V(0,1, 5,1, 5,1, 6,1,0,0,  0,0,1,1,0,0,0,0,0));
    vecs.push_back(V(0,0, 0,0, 0,0, 0,0,0,0,  0,0,1,1,0,0,0,0,0));
    vecs.push_back(V(0,1, 1,1, 2,1,10,1,0,0,  0,0,1,1,0,0,0,0,0)); // add x10
    vecs.push_back(V(0,1, 3,1,10,1,11,1,0,0,  0,0,0,0,0,1,0,0,0)); // rs2 EX match
    vecs.push_back(V(0,1, 3,1,10,1,11,1,0,0,  0,0,0,0,0,1,1,1,0));
    vecs.push_back(V(0,1, 3,1,10,1,11,1,0,0,  0,0,1,1,0,0,1,2,0));
    vecs.push_back(V(0,0,11,1,11,1,12,1,0,0,  0,0,1,1,0,0,0,2,0)); // id_valid low
    vecs.push_back(V(0,1, 1,1, 2,1,12,0,0,0,  0,0,1,1,0,0,0,2,0)); // no regwrite
    vecs.push_back(V(0,1,12,1,12,1,13,1,0,0,  0,0,1,1,0,0,0,2,0));
`endif

    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_regwrite = 1'b0;
    id_memread = 1'b0; ex_branch_taken = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      t = vecs[i];
      t.idx = i;
      @(posedge clk);
      #1;
      reset = t.rst; id_valid = t.v; id_rs1 = t.rs1; id_uses_rs1 = t.u1;
      id_rs2 = t.rs2; id_uses_rs2 = t.u2; id_rd = t.rd; id_regwrite = t.rw;
      id_memread = t.mr; ex_branch_taken = t.br;
      exp_q.push_back(t);
    end

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
